// File: rtl/haar_pkg.sv
// Shared definitions for the Haar cascade stage evaluator.
//   clog2         : constant-width helper used for counter and sum widths
//   CORNER_*      : position of each integral-image corner within a rectangle's corner group
//   haar_state_e  : stage-evaluator FSM states
package haar_pkg;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

    localparam int CORNER_A = 0;
    localparam int CORNER_B = 1;
    localparam int CORNER_C = 2;
    localparam int CORNER_D = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } haar_state_e;

endpackage

// File: rtl/haar_rect_sum.sv
// Registered rectangle sum from four integral-image corners: (a+d)-(b+c).
// Ports:
//   clk, rst  : clock, synchronous active-low reset
//   corners   : four unsigned II_W corners, a,b,c,d from the LSB
//   rect_sum  : signed II_W+2 rectangle sum, valid one cycle after corners
module haar_rect_sum
    import haar_pkg::*;
#(
    parameter int II_W = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4*II_W-1:0]      corners,
    output logic signed [II_W+1:0] rect_sum
);

    logic [II_W-1:0]        corner_a;
    logic [II_W-1:0]        corner_b;
    logic [II_W-1:0]        corner_c;
    logic [II_W-1:0]        corner_d;
    logic [II_W:0]          sum_ad;
    logic [II_W:0]          sum_bc;
    logic signed [II_W+1:0] diff;

    assign corner_a = corners[CORNER_A*II_W +: II_W];
    assign corner_b = corners[CORNER_B*II_W +: II_W];
    assign corner_c = corners[CORNER_C*II_W +: II_W];
    assign corner_d = corners[CORNER_D*II_W +: II_W];

    // Pair sums are carried one bit wider so neither addition can overflow;
    // one more bit on the difference holds the full signed range.
    assign sum_ad = {1'b0, corner_a} + {1'b0, corner_d};
    assign sum_bc = {1'b0, corner_b} + {1'b0, corner_c};
    assign diff   = $signed({1'b0, sum_ad}) - $signed({1'b0, sum_bc});

    always_ff @(posedge clk) begin
        if (!rst) begin
            rect_sum <= '0;
        end else begin
            rect_sum <= diff;
        end
    end

endmodule

// File: rtl/haar_stage_evaluator.sv
// One Haar cascade stage: streams weak-classifier features, accumulates leaf
// values with saturation and reports a pass/fail verdict against the stage
// threshold.
// Ports:
//   clk, rst         : clock, synchronous active-low reset
//   start            : begin a stage (accepted only in IDLE)
//   num_features     : feature count for the stage, latched on start
//   stage_threshold  : signed stage threshold, latched on start
//   f_valid/f_ready  : feature beat handshake
//   f_ii, f_weight   : per-rectangle corners and signed weights
//   f_threshold      : signed feature threshold
//   f_left, f_right  : leaf values for feature <= / > threshold
//   busy             : high outside IDLE
//   stage_done       : one-cycle completion pulse
//   stage_pass       : verdict, held until the next accepted start
//   accum            : signed running stage sum
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_RUN   | accepting feature beats until num_features are taken
// ST_DRAIN | all beats taken, waiting for the pipeline to retire them
// ST_DONE  | stage_done pulse, verdict valid
module haar_stage_evaluator
    import haar_pkg::*;
#(
    parameter int II_W         = 18,
    parameter int NUM_RECTS    = 3,
    parameter int WGT_W        = 4,
    parameter int VAL_W        = 16,
    parameter int FTHR_W       = 24,
    parameter int ACC_W        = 16,
    parameter int MAX_FEATURES = 255
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [clog2(MAX_FEATURES+1)-1:0]       num_features,
    input  logic [ACC_W-1:0]                       stage_threshold,
    input  logic                                   f_valid,
    output logic                                   f_ready,
    input  logic [NUM_RECTS*4*II_W-1:0]            f_ii,
    input  logic [NUM_RECTS*WGT_W-1:0]             f_weight,
    input  logic [FTHR_W-1:0]                      f_threshold,
    input  logic [VAL_W-1:0]                       f_left,
    input  logic [VAL_W-1:0]                       f_right,
    output logic                                   busy,
    output logic                                   stage_done,
    output logic                                   stage_pass,
    output logic [ACC_W-1:0]                       accum
);

    localparam int CNT_W  = clog2(MAX_FEATURES + 1);
    localparam int FEAT_W = II_W + 2 + WGT_W + clog2(NUM_RECTS);
    localparam int CMP_W  = ((FEAT_W > FTHR_W) ? FEAT_W : FTHR_W) + 1;
    localparam int SUM_W  = ((ACC_W > VAL_W) ? ACC_W : VAL_W) + 1;

    localparam logic signed [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] ACC_MIN = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

    haar_state_e state_q;
    haar_state_e state_d;

    logic [CNT_W-1:0]        num_q;
    logic [CNT_W-1:0]        acc_cnt;
    logic [CNT_W-1:0]        ret_cnt;
    logic signed [ACC_W-1:0] sthr_q;
    logic signed [ACC_W-1:0] accum_q;
    logic                    pass_q;
    logic                    start_ok;
    logic                    hs;

    // S1: rect sums come out of the sub-modules; side data travels alongside.
    logic                           v1;
    logic signed [II_W+1:0]         rect_s1 [NUM_RECTS];
    logic [NUM_RECTS*WGT_W-1:0]     w1;
    logic signed [FTHR_W-1:0]       thr1;
    logic signed [VAL_W-1:0]        left1;
    logic signed [VAL_W-1:0]        right1;

    // S2: weighted feature value.
    logic                           v2;
    logic signed [FEAT_W-1:0]       feat_sum;
    logic signed [FEAT_W-1:0]       feat2;
    logic signed [FTHR_W-1:0]       thr2;
    logic signed [VAL_W-1:0]        left2;
    logic signed [VAL_W-1:0]        right2;

    logic signed [CMP_W-1:0]        feat_cmp;
    logic signed [CMP_W-1:0]        thr_cmp;
    logic signed [VAL_W-1:0]        leaf;
    logic signed [SUM_W-1:0]        acc_ext;
    logic signed [SUM_W-1:0]        leaf_ext;
    logic signed [SUM_W-1:0]        acc_sum;
    logic signed [ACC_W-1:0]        acc_sat;

    genvar k;
    generate
        for (k = 0; k < NUM_RECTS; k++) begin : g_rect
            haar_rect_sum #(
                .II_W(II_W)
            ) u_rect (
                .clk      (clk),
                .rst      (rst),
                .corners  (f_ii[k*4*II_W +: 4*II_W]),
                .rect_sum (rect_s1[k])
            );
        end
    endgenerate

    assign start_ok = (state_q == ST_IDLE) && start;
    assign f_ready  = (state_q == ST_RUN) && (acc_cnt < num_q);
    assign hs       = f_valid && f_ready;

    always_comb begin
        logic signed [FEAT_W-1:0] r_ext;
        logic signed [FEAT_W-1:0] w_ext;
        feat_sum = '0;
        r_ext    = '0;
        w_ext    = '0;
        for (int i = 0; i < NUM_RECTS; i++) begin
            r_ext    = {{(FEAT_W-II_W-2){rect_s1[i][II_W+1]}}, rect_s1[i]};
            w_ext    = {{(FEAT_W-WGT_W){w1[i*WGT_W+WGT_W-1]}}, w1[i*WGT_W +: WGT_W]};
            feat_sum = feat_sum + r_ext * w_ext;
        end
    end

    always_comb begin
        feat_cmp = {{(CMP_W-FEAT_W){feat2[FEAT_W-1]}}, feat2};
        thr_cmp  = {{(CMP_W-FTHR_W){thr2[FTHR_W-1]}}, thr2};
        leaf     = (feat_cmp > thr_cmp) ? right2 : left2;
        acc_ext  = {{(SUM_W-ACC_W){accum_q[ACC_W-1]}}, accum_q};
        leaf_ext = {{(SUM_W-VAL_W){leaf[VAL_W-1]}}, leaf};
        acc_sum  = acc_ext + leaf_ext;
        if (acc_sum > ACC_MAX) begin
            acc_sat = ACC_MAX[ACC_W-1:0];
        end else if (acc_sum < ACC_MIN) begin
            acc_sat = ACC_MIN[ACC_W-1:0];
        end else begin
            acc_sat = acc_sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (num_features == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (hs && ((acc_cnt + CNT_W'(1)) == num_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave on the cycle the last beat retires so DONE lands one cycle later.
                if (v2 && ((ret_cnt + CNT_W'(1)) == num_q)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            v1      <= 1'b0;
            w1      <= '0;
            thr1    <= '0;
            left1   <= '0;
            right1  <= '0;
            v2      <= 1'b0;
            feat2   <= '0;
            thr2    <= '0;
            left2   <= '0;
            right2  <= '0;
            num_q   <= '0;
            acc_cnt <= '0;
            ret_cnt <= '0;
            sthr_q  <= '0;
            accum_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            v1     <= hs;
            w1     <= f_weight;
            thr1   <= f_threshold;
            left1  <= f_left;
            right1 <= f_right;
            v2     <= v1;
            feat2  <= feat_sum;
            thr2   <= thr1;
            left2  <= left1;
            right2 <= right1;
            if (start_ok) begin
                num_q   <= num_features;
                sthr_q  <= stage_threshold;
                accum_q <= '0;
                acc_cnt <= '0;
                ret_cnt <= '0;
                // An empty stage finishes with accum=0, so the verdict is just 0 > threshold.
                pass_q  <= (num_features == '0) ? stage_threshold[ACC_W-1] : 1'b0;
            end else begin
                if (hs) begin
                    acc_cnt <= acc_cnt + CNT_W'(1);
                end
                if (v2) begin
                    accum_q <= acc_sat;
                    ret_cnt <= ret_cnt + CNT_W'(1);
                end
                if ((state_q == ST_DRAIN) && (state_d == ST_DONE)) begin
                    pass_q <= (acc_sat > sthr_q);
                end
            end
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign stage_done = (state_q == ST_DONE);
    assign stage_pass = pass_q;
    assign accum      = accum_q;

endmodule

// File: tb/tb_haar_stage_evaluator.sv
module tb_haar_stage_evaluator;

    localparam int II_W  = 18;
    localparam int NR    = 3;
    localparam int WGT_W = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   start = 1'b0;
    logic [7:0]             num_features = '0;
    logic [15:0]            stage_threshold = '0;
    logic                   f_valid = 1'b0;
    logic                   f_ready;
    logic [NR*4*II_W-1:0]   f_ii = '0;
    logic [NR*WGT_W-1:0]    f_weight = '0;
    logic [23:0]            f_threshold = '0;
    logic [15:0]            f_left = '0;
    logic [15:0]            f_right = '0;
    logic                   busy;
    logic                   stage_done;
    logic                   stage_pass;
    logic [15:0]            accum;

    int errors = 0;
    int checks = 0;

    int t_ii    [256][NR][4];
    int t_w     [256][NR];
    int t_thr   [256];
    int t_left  [256];
    int t_right [256];

    haar_stage_evaluator dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .num_features    (num_features),
        .stage_threshold (stage_threshold),
        .f_valid         (f_valid),
        .f_ready         (f_ready),
        .f_ii            (f_ii),
        .f_weight        (f_weight),
        .f_threshold     (f_threshold),
        .f_left          (f_left),
        .f_right         (f_right),
        .busy            (busy),
        .stage_done      (stage_done),
        .stage_pass      (stage_pass),
        .accum           (accum)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_tab(input int i);
        for (int r = 0; r < NR; r++) begin
            for (int c = 0; c < 4; c++) t_ii[i][r][c] = 0;
            t_w[i][r] = 0;
        end
        t_thr[i] = 0;
        t_left[i] = 0;
        t_right[i] = 0;
    endtask

    task automatic set_rect(input int i, input int r, input int a, input int b,
                            input int c, input int d, input int w);
        t_ii[i][r][0] = a;
        t_ii[i][r][1] = b;
        t_ii[i][r][2] = c;
        t_ii[i][r][3] = d;
        t_w[i][r]     = w;
    endtask

    task automatic set_beat(input int i);
        int v;
        for (int r = 0; r < NR; r++) begin
            for (int c = 0; c < 4; c++) begin
                v = t_ii[i][r][c];
                f_ii[(r*4+c)*II_W +: II_W] = v[II_W-1:0];
            end
            v = t_w[i][r];
            f_weight[r*WGT_W +: WGT_W] = v[WGT_W-1:0];
        end
        v = t_thr[i];   f_threshold = v[23:0];
        v = t_left[i];  f_left      = v[15:0];
        v = t_right[i]; f_right     = v[15:0];
    endtask

    function automatic longint feat_val(input int i);
        longint s;
        s = 0;
        for (int r = 0; r < NR; r++) begin
            s += longint'((t_ii[i][r][0] + t_ii[i][r][3]) - (t_ii[i][r][1] + t_ii[i][r][2]))
                 * longint'(t_w[i][r]);
        end
        return s;
    endfunction

    function automatic int model_accum(input int nf);
        int acc;
        acc = 0;
        for (int i = 0; i < nf; i++) begin
            acc += (feat_val(i) > longint'(t_thr[i])) ? t_right[i] : t_left[i];
            if (acc > 32767) acc = 32767;
            if (acc < -32768) acc = -32768;
        end
        return acc;
    endfunction

    // Runs one stage from start to a few cycles past its done pulse and reports what it saw.
    task automatic run_stage(input int nf, input int sthr, input int bubble_pct,
                             input bit busy_start, input bit extra_valid,
                             output int done_cnt, output int done_lat, output int acc_done,
                             output logic pass_done, output int accepted, output int extra_hs,
                             output bit dropped, output bit timeout);
        int cyc, last_hs, done_cyc, prev_acc;
        bit hs;
        done_cnt = 0; done_lat = -1; acc_done = 0; pass_done = 1'b0;
        accepted = 0; extra_hs = 0; dropped = 1'b0; timeout = 1'b0;
        last_hs = 0; done_cyc = -1; prev_acc = 0;
        @(posedge clk); #1;
        start = 1'b1;
        num_features = nf[7:0];
        stage_threshold = sthr[15:0];
        f_valid = 1'b0;
        @(posedge clk); #1;
        cyc = 1;
        while (1) begin
            start = (busy_start && cyc == 3);
            if (accepted < nf) begin
                f_valid = ($urandom_range(99) >= bubble_pct);
                set_beat(accepted);
            end else begin
                f_valid = extra_valid && (done_cnt == 0);
                if (f_valid) set_beat(0);
            end
            @(negedge clk);
            hs = f_valid && f_ready;
            if (hs && accepted >= nf) extra_hs++;
            if ($signed(accum) < prev_acc) dropped = 1'b1;
            prev_acc = $signed(accum);
            if (stage_done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_cyc  = cyc;
                    done_lat  = cyc - last_hs;
                    acc_done  = $signed(accum);
                    pass_done = stage_pass;
                end
            end
            @(posedge clk); #1;
            if (hs && accepted < nf) begin
                accepted++;
                last_hs = cyc;
            end
            cyc++;
            if (done_cyc >= 0 && cyc > done_cyc + 4) break;
            if (cyc > 2000) begin
                timeout = 1'b1;
                break;
            end
        end
        f_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic load_four();
        clear_tab(0); set_rect(0, 0, 50, 0, 0, 0, 1);
        t_thr[0] = 40;  t_right[0] = 100; t_left[0] = -50;
        clear_tab(1); set_rect(1, 0, 10, 20, 0, 0, 3);
        t_thr[1] = -31; t_right[1] = -70; t_left[1] = 90;
        clear_tab(2); set_rect(2, 1, 5, 0, 0, 5, -2);
        t_thr[2] = -20; t_right[2] = -1;  t_left[2] = 33;
        clear_tab(3); set_rect(3, 2, 0, 0, 7, 0, -4);
        t_thr[3] = 100; t_right[3] = -9;  t_left[3] = 12;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (stage_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", stage_done); end
        checks++; if (stage_pass !== 1'b0) begin errors++; $display("FAIL reset_pass: got %b expected 0", stage_pass); end
        checks++; if (accum !== 16'd0) begin errors++; $display("FAIL reset_accum: got %0d expected 0", $signed(accum)); end
        checks++; if (f_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", f_ready); end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_single(input int fthr, input int exp_acc, input logic exp_pass, input string tag);
        int dc, dl, ad, acc_n, xh; logic pd; bit dr, to;
        clear_tab(0);
        set_rect(0, 0, 10, 5, 5, 10, -1);
        set_rect(0, 1, 20, 0, 0, 0, 2);
        set_rect(0, 2, 7, 1, 2, 3, 0);
        t_thr[0] = fthr; t_right[0] = 5; t_left[0] = -3;
        run_stage(1, 4, 0, 1'b0, 1'b0, dc, dl, ad, pd, acc_n, xh, dr, to);
        checks++; if (to) begin errors++; $display("FAIL %s_timeout: no stage_done within budget", tag); end
        checks++; if (dl != 3) begin errors++; $display("FAIL %s_latency: got %0d expected 3", tag, dl); end
        checks++; if (dc != 1) begin errors++; $display("FAIL %s_done_count: got %0d expected 1", tag, dc); end
        checks++; if (ad != exp_acc) begin errors++; $display("FAIL %s_accum: got %0d expected %0d", tag, ad, exp_acc); end
        checks++; if (pd !== exp_pass) begin errors++; $display("FAIL %s_pass: got %b expected %b", tag, pd, exp_pass); end
        @(negedge clk);
        checks++; if (stage_pass !== exp_pass) begin errors++; $display("FAIL %s_pass_held: got %b expected %b", tag, stage_pass, exp_pass); end
        checks++; if ($signed(accum) != exp_acc) begin errors++; $display("FAIL %s_accum_held: got %0d expected %0d", tag, $signed(accum), exp_acc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_idle: got busy=%b expected 0", tag, busy); end
    endtask

    task automatic test_saturation();
        int dc, dl, ad, acc_n, xh; logic pd; bit dr, to;
        for (int i = 0; i < 255; i++) begin
            clear_tab(i);
            set_rect(i, 0, 100, 0, 0, 0, 1);
            t_thr[i] = 0; t_right[i] = 200; t_left[i] = -200;
        end
        run_stage(255, 0, 0, 1'b0, 1'b1, dc, dl, ad, pd, acc_n, xh, dr, to);
        checks++; if (to) begin errors++; $display("FAIL sat_timeout: no stage_done within budget"); end
        checks++; if (acc_n != 255) begin errors++; $display("FAIL sat_accepted: got %0d expected 255", acc_n); end
        checks++; if (xh != 0) begin errors++; $display("FAIL sat_extra_beat: got %0d accepted expected 0", xh); end
        checks++; if (ad != 32767) begin errors++; $display("FAIL sat_accum: got %0d expected 32767", ad); end
        checks++; if (pd !== 1'b1) begin errors++; $display("FAIL sat_pass: got %b expected 1", pd); end
        checks++; if (dr) begin errors++; $display("FAIL sat_wrap: got accum decrease expected none"); end
        checks++; if (dl != 3) begin errors++; $display("FAIL sat_latency: got %0d expected 3", dl); end
        checks++; if (dc != 1) begin errors++; $display("FAIL sat_done_count: got %0d expected 1", dc); end
    endtask

    task automatic test_zero_features();
        int dc, dl, ad, acc_n, xh; logic pd; bit dr, to;
        run_stage(0, -1, 0, 1'b0, 1'b0, dc, dl, ad, pd, acc_n, xh, dr, to);
        checks++; if (to) begin errors++; $display("FAIL zero_timeout: no stage_done within budget"); end
        checks++; if (dl != 1) begin errors++; $display("FAIL zero_latency: got %0d expected 1", dl); end
        checks++; if (pd !== 1'b1) begin errors++; $display("FAIL zero_pass: got %b expected 1", pd); end
        checks++; if (ad != 0) begin errors++; $display("FAIL zero_accum: got %0d expected 0", ad); end
        checks++; if (dc != 1) begin errors++; $display("FAIL zero_done_count: got %0d expected 1", dc); end
        run_stage(0, 0, 0, 1'b0, 1'b0, dc, dl, ad, pd, acc_n, xh, dr, to);
        checks++; if (pd !== 1'b0) begin errors++; $display("FAIL zero_pass_eq: got %b expected 0", pd); end
    endtask

    task automatic test_extremes();
        int dc, dl, ad, acc_n, xh; logic pd; bit dr, to;
        // feature0 = 524286*7 + 2*(-524286*-8) = 12058578, above the largest threshold
        clear_tab(0);
        set_rect(0, 0, 262143, 0, 0, 262143, 7);
        set_rect(0, 1, 0, 262143, 262143, 0, -8);
        set_rect(0, 2, 0, 262143, 262143, 0, -8);
        t_thr[0] = 8388607; t_right[0] = 7; t_left[0] = -7;
        // feature1 = -12058578 + ... = -11534292, below the smallest threshold
        clear_tab(1);
        set_rect(1, 0, 262143, 0, 0, 262143, -8);
        set_rect(1, 1, 0, 262143, 262143, 0, 7);
        set_rect(1, 2, 0, 262143, 262143, 0, 7);
        t_thr[1] = -8388608; t_right[1] = 9; t_left[1] = -9;
        run_stage(2, -3, 0, 1'b0, 1'b0, dc, dl, ad, pd, acc_n, xh, dr, to);
        checks++; if (to) begin errors++; $display("FAIL ext_timeout: no stage_done within budget"); end
        checks++; if (ad != -2) begin errors++; $display("FAIL ext_accum: got %0d expected -2", ad); end
        checks++; if (pd !== 1'b1) begin errors++; $display("FAIL ext_pass: got %b expected 1", pd); end
    endtask

    task automatic test_bubbles_busy_start();
        int dc, dl, ad, acc_n, xh, exp_acc; logic pd; bit dr, to;
        load_four();
        exp_acc = model_accum(4);
        run_stage(4, 74, 40, 1'b1, 1'b0, dc, dl, ad, pd, acc_n, xh, dr, to);
        checks++; if (to) begin errors++; $display("FAIL bub_timeout: no stage_done within budget"); end
        checks++; if (ad != exp_acc) begin errors++; $display("FAIL bub_accum: got %0d expected %0d", ad, exp_acc); end
        checks++; if (pd !== (exp_acc > 74)) begin errors++; $display("FAIL bub_pass: got %b expected %b", pd, exp_acc > 74); end
        checks++; if (dc != 1) begin errors++; $display("FAIL bub_done_count: got %0d expected 1", dc); end
        checks++; if (acc_n != 4) begin errors++; $display("FAIL bub_accepted: got %0d expected 4", acc_n); end
        checks++; if (dl != 3) begin errors++; $display("FAIL bub_latency: got %0d expected 3", dl); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bub_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_reset_mid_run();
        int dc, dl, ad, acc_n, xh, exp_acc, stray; logic pd; bit dr, to;
        load_four();
        @(posedge clk); #1;
        start = 1'b1; num_features = 8'd4; stage_threshold = 16'd74;
        @(posedge clk); #1;
        start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            set_beat(b);
            f_valid = 1'b1;
            @(posedge clk); #1;
        end
        f_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if ($signed(accum) != 30) begin errors++; $display("FAIL mid_accum: got %0d expected 30", $signed(accum)); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", busy); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (accum !== 16'd0) begin errors++; $display("FAIL rst_accum: got %0d expected 0", $signed(accum)); end
        checks++; if (stage_pass !== 1'b0) begin errors++; $display("FAIL rst_pass: got %b expected 0", stage_pass); end
        checks++; if (f_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", f_ready); end
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            if (stage_done) stray++;
            @(negedge clk);
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL rst_no_done: got %0d pulses expected 0", stray); end
        exp_acc = model_accum(4);
        run_stage(4, 74, 0, 1'b0, 1'b0, dc, dl, ad, pd, acc_n, xh, dr, to);
        checks++; if (to) begin errors++; $display("FAIL post_timeout: no stage_done within budget"); end
        checks++; if (ad != exp_acc) begin errors++; $display("FAIL post_accum: got %0d expected %0d", ad, exp_acc); end
        checks++; if (pd !== (exp_acc > 74)) begin errors++; $display("FAIL post_pass: got %b expected %b", pd, exp_acc > 74); end
        checks++; if (dc != 1) begin errors++; $display("FAIL post_done_count: got %0d expected 1", dc); end
    endtask

    initial begin
        test_reset();
        test_single(29, 5, 1'b1, "right");
        test_single(30, -3, 1'b0, "equal");
        test_saturation();
        test_zero_features();
        test_extremes();
        test_bubbles_busy_start();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/haar_stage_evaluator.md
Name: haar_stage_evaluator

Overview:
- Parametrised successor to the single-feature Haar classifier. Evaluates one complete cascade stage: it accepts a stream of N weak-classifier features, one per handshake.
- For each feature: computes the NUM_RECTS weighted rectangle sums from integral-image corners, compares the sum with the feature threshold, and accumulates the right or left leaf value into a saturating accumulator.
- After the last feature it raises a one-cycle done pulse with a pass/fail verdict against the stage threshold.
- Sits between the integral-image window fetch and the cascade controller.

Parameters:
- II_W, 18, unsigned integral-image corner width.
- NUM_RECTS, 3, rectangles per feature (1..4).
- WGT_W, 4, signed rectangle weight width.
- VAL_W, 16, signed leaf value width (left/right).
- FTHR_W, 24, signed feature threshold width.
- ACC_W, 16, signed stage accumulator and stage threshold width.
- MAX_FEATURES, 255, maximum features per stage.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset (clears the block when sampled low on a clk rising edge).
- start  in  1  begin a stage; honoured only in IDLE.
- num_features  in  clog2(MAX_FEATURES+1)  feature count, latched on start.
- stage_threshold  in  ACC_W  signed, latched on start.
- f_valid  in  1  feature beat valid.
- f_ready  out  1  feature beat accepted when f_valid&f_ready.
- f_ii  in  NUM_RECTS*4*II_W  corners; rect k at [k*4*II_W +: 4*II_W], ordered a,b,c,d from LSB.
- f_weight  in  NUM_RECTS*WGT_W  signed weights; rect k at [k*WGT_W +: WGT_W].
- f_threshold  in  FTHR_W  signed feature threshold.
- f_left  in  VAL_W  signed, used when feature <= threshold.
- f_right  in  VAL_W  signed, used when feature > threshold.
- busy  out  1  high outside IDLE.
- stage_done  out  1  one-cycle pulse.
- stage_pass  out  1  verdict, held until next accepted start.
- accum  out  ACC_W  signed running stage sum.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; in-flight pipeline contents discarded. A reset mid-stage aborts the stage with no done pulse.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start with num_features>0. Latches the count and threshold, clears accum and the accepted/retired counters.
  - IDLE -> DONE on start with num_features==0.
  - RUN -> DRAIN when the accepted count reaches num_features.
  - DRAIN -> DONE when the retired count reaches num_features.
  - DONE -> IDLE after one cycle.
- start outside IDLE is ignored.
- f_ready = (state==RUN) && accepted<num_features. The pipeline never stalls; f_valid bubbles are allowed.
- Pipeline, for a handshake in cycle n:
  - S1, registered end of n: rect_k = (a+d)-(b+c), signed II_W+2.
  - S2, registered end of n+1: feature = sum of rect_k*weight_k, signed, full width II_W+2+WGT_W+clog2(NUM_RECTS). No truncation.
  - End of n+2: select f_right if feature > sign-extended f_threshold (strictly greater, signed), else f_left. Add the selected value to accum with saturation to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Threshold and leaf values travel with the beat through the pipeline.
- Completion:
  - stage_done is high in cycle n+3 for the last feature, with stage_pass = (final accum > stage_threshold), signed strict.
  - For num_features==0: stage_done is high in cycle m+1 after start in cycle m, with accum=0 and stage_pass = (0 > stage_threshold).
- Back-to-back stages: a start in the DONE-following IDLE cycle is accepted. accum holds its last value until the next start clears it.

Decomposition:
- haar_pkg holds:
  - the clog2 function;
  - localparams for corner ordering indices (A=0,B=1,C=2,D=3);
  - the FSM state enum.
- One sub-module, haar_rect_sum, computes the S1 rect sum for a single rectangle and is instantiated NUM_RECTS times via generate.
- Weighting, compare, accumulation and FSM stay in the top module.

Test Plan:
- Single feature, defaults:
  - Stimulus: rect0 a=10,b=5,c=5,d=10, w0=-1; rect1 a=20, others 0, w1=2; rect2 w2=0; feature=30; f_threshold=29; right=5, left=-3; stage_threshold=4.
  - Response: stage_done in cycle n+3, accum=5, stage_pass=1.
- Same as above with f_threshold=30:
  - Response: accum=-3, stage_pass=0 (equality selects left).
- 255 features, each right=200, all above threshold, fed every cycle:
  - Response: accum saturates at 32767 and never wraps; stage_pass=1.
  - f_ready drops after the 255th beat; an extra f_valid beat is not accepted.
- num_features=0 with stage_threshold=-1, start in cycle m:
  - Response: stage_done in cycle m+1, stage_pass=1, accum=0.
- 4 features with random f_valid bubbles, plus a start pulse while busy:
  - Response: the start is ignored; the result equals the golden model; exactly one done pulse.
- Reset asserted low for 1 cycle mid-RUN, after 2 of 4 beats:
  - Response: all outputs return to 0 and no stage_done follows.
  - A subsequent full stage produces the correct result.
